result_reader: RTL and testbench

Read-back engine for the convolution result BRAM. After the result writer has filled the output feature maps, this block sweeps the BRAM port B linearly, absorbs the fixed BRAM read latency, and streams the words out on a valid/ready interface. It marks map and frame boundaries for the host DMA or the next layer's input loader. It sits between the result BRAM read port and the downstream consumer, and is kicked once per layer by the top-level controller.

---
 rtl/result_reader.sv | 183 ++++++++++++++++++
 tb/tb_result_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_reader.sv
// Result BRAM read-back engine: linear port-B sweep, credit-limited read issue, latency-absorbing FIFO, valid/ready stream out.
// Optional macro RESULT_READER_RELU_EN zeroes negative words at the stream output.
module result_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] map_words,
  input  logic [7:0]        map_num,
  output logic              o_enb,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last_map,
  output logic              o_last,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_word;
  logic [ADDR_W-1:0]   r_map_words;
  logic [7:0]          r_map;
  logic [7:0]          r_map_num;
  logic                r_busy;
  logic                r_done;

  logic [RD_LAT-1:0]   r_pipe_vld;
  logic [RD_LAT-1:0]   r_pipe_lm;
  logic [RD_LAT-1:0]   r_pipe_l;

  logic [DATA_W+1:0]   r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;

  logic [CW-1:0]       w_inflight;
  logic [CW-1:0]       w_total;
  logic                w_issue;
  logic                w_last_map;
  logic                w_last;
  logic                w_wr;
  logic                w_pop;
  logic                w_pipe_empty;
  logic [DATA_W+1:0]   w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_pipe_vld[i]);
    end
  end

  // Reads in flight plus buffered words never exceed the FIFO depth, so back-pressure cannot overflow it.
  assign w_total      = w_inflight + r_count;
  assign w_issue      = (r_state == ISSUE) && (w_total < CW'(DEPTH));
  assign w_last_map   = (r_word == r_map_words - ADDR_W'(1));
  assign w_last       = w_last_map && (r_map == r_map_num - 8'd1);
  assign w_wr         = r_pipe_vld[RD_LAT-1];
  assign w_pop        = o_valid && i_ready;
  assign w_pipe_empty = (w_inflight == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_word      <= '0;
      r_map_words <= '0;
      r_map       <= '0;
      r_map_num   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_map_words <= map_words;
            r_map_num   <= map_num;
            r_word      <= '0;
            r_map       <= '0;
            r_busy      <= 1'b1;
            if (map_words != '0 && map_num != 8'd0) begin
              r_state <= ISSUE;
            end else begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_issue) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_last_map) begin
              r_word <= '0;
              r_map  <= r_map + 8'd1;
            end else begin
              r_word <= r_word + ADDR_W'(1);
            end
            if (w_last) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as the final beat is accepted so done lands on the very next cycle.
          if (w_pipe_empty && (r_count == '0 || (r_count == CW'(1) && w_pop))) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pipe_vld <= '0;
      r_pipe_lm  <= '0;
      r_pipe_l   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_lm[0]  <= w_issue && w_last_map;
      r_pipe_l[0]   <= w_issue && w_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_lm[i]  <= r_pipe_lm[i-1];
        r_pipe_l[i]   <= r_pipe_l[i-1];
      end
      if (w_wr)  r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Flags ride alongside the word in the upper two bits of each entry.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_pipe_l[RD_LAT-1], r_pipe_lm[RD_LAT-1], i_rdata};
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign o_valid    = (r_count != '0);
  assign o_last     = o_valid && w_head[DATA_W+1];
  assign o_last_map = o_valid && w_head[DATA_W];
`ifdef RESULT_READER_RELU_EN
  assign o_data     = (o_valid && !w_head[DATA_W-1]) ? w_head[DATA_W-1:0] : '0;
`else
  assign o_data     = o_valid ? w_head[DATA_W-1:0] : '0;
`endif
  assign o_enb      = w_issue;
  assign o_rd_addr  = r_addr;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: BRAM model, queued expected beats/addresses, negedge monitor.
module tb_result_reader;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] map_words = '0;
  logic [7:0]    map_num = '0;
  logic          o_enb;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rdata;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic          o_last_map;
  logic          o_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  result_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .map_words(map_words), .map_num(map_num), .o_enb(o_enb),
    .o_rd_addr(o_rd_addr), .i_rdata(i_rdata), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_last_map(o_last_map),
    .o_last(o_last), .busy(busy), .done(done)
  );

  // BRAM model with two-cycle read latency
  logic [DW-1:0] mem [65536];
  logic [AW-1:0] a1;
  always @(posedge clk) begin
    a1      <= o_rd_addr;
    i_rdata <= mem[a1];
  end

  typedef struct {
    logic [DW-1:0] d;
    logic          lm;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  int first_valid_cyc, done_cyc, last_acc_cyc, enb_count, outstanding, max_out;
  bit prev_stall, prev_done;
  logic [DW+2:0] prev_out;
  beat_t mon_e;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w);
`ifdef RESULT_READER_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int ph;
    logic [3:0] pat;
    pat = 4'b1001;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: i_ready = 1'b1;
        1: i_ready = pat[3 - (ph % 4)];
        2: i_ready = ($urandom_range(0, 1) == 1);
        default: i_ready = 1'b0;
      endcase
      ph++;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (o_enb) begin
        enb_count++;
        outstanding++;
        if (addr_q.size() == 0) chk("rd_addr_extra", 1, 0);
        else chk("rd_addr", o_rd_addr, addr_q.pop_front());
      end
      if (outstanding > max_out) max_out = outstanding;
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) chk("stall_hold", {o_valid, o_last_map, o_last, o_data}, prev_out);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("beat_extra", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          $display("beat data=%08h last_map=%0b last=%0b", o_data, o_last_map, o_last);
          chk("beat_data", o_data, mon_e.d);
          chk("beat_last_map", o_last_map, mon_e.lm);
          chk("beat_last", o_last, mon_e.l);
        end
        outstanding--;
        last_acc_cyc = cyc;
      end
      prev_stall = o_valid && !i_ready;
      prev_out   = {o_valid, o_last_map, o_last, o_data};
      if (prev_done) chk("busy_after_done", busy, 0);
      if (done) done_cyc = cyc;
      prev_done = done;
    end
  end

  task automatic push_exp(input logic [AW-1:0] b, input int mw, input int mn);
    int total;
    logic [AW-1:0] a;
    total = mw * mn;
    for (int i = 0; i < total; i++) begin
      a = b + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back('{model_word(mem[a]), (i % mw) == mw - 1, i == total - 1});
    end
  endtask

  task automatic start_frame(input logic [AW-1:0] b, input int mw, input int mn, output int c0);
    first_valid_cyc = -1;
    done_cyc = -1;
    enb_count = 0;
    max_out = 0;
    outstanding = 0;
    push_exp(b, mw, mn);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    map_words = AW'(mw);
    map_num = 8'(mn);
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'($urandom);
    map_words = AW'($urandom);
    map_num = 8'($urandom);
    chk("busy_cycle1", busy, 1);
    chk("enb_cycle1", o_enb, (mw * mn) > 0);
  endtask

  task automatic run_frame(input logic [AW-1:0] b, input int mw, input int mn,
                           input int mode, input bit dup_start, input bit timing);
    int c0, n, total;
    total = mw * mn;
    ready_mode = mode;
    $display("frame base=%04h map_words=%0d map_num=%0d ready_mode=%0d", b, mw, mn, mode);
    start_frame(b, mw, mn, c0);
    if (dup_start) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (done_cyc < 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done_cyc >= 0, 1);
    repeat (2) @(negedge clk);
    chk("beats_left", exp_q.size() + addr_q.size(), 0);
    chk("credit_exceeded", max_out > 4, 0);
    if (total > 0) chk("done_after_last", done_cyc, last_acc_cyc + 1);
    else begin
      chk("zero_done_cycle", done_cyc, c0 + 1);
      chk("zero_enb_count", enb_count, 0);
    end
    if (timing) begin
      chk("first_valid_cycle", first_valid_cyc - c0, 4);
      chk("throughput", last_acc_cyc - first_valid_cyc, total - 1);
    end
  endtask

  initial begin
    int c0, mw, mn, n;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[16'h0200] = 32'hFFFF_FFF0;
    mem[16'h0201] = 32'h0000_0005;
    first_valid_cyc = -1;
    done_cyc = -1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_enb, o_rd_addr, o_data, o_valid, o_last_map, o_last, busy, done}, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_frame(16'h0010, 4, 2, 0, 1'b0, 1'b1);
    run_frame(16'h0010, 4, 2, 1, 1'b0, 1'b0);
    run_frame(16'h0040, 3, 0, 0, 1'b0, 1'b0);
    run_frame(16'hFFFE, 4, 1, 0, 1'b0, 1'b1);
    run_frame(16'h0200, 2, 1, 0, 1'b0, 1'b0);

    // reset mid-frame with three words buffered
    ready_mode = 3;
    start_frame(16'h0100, 8, 2, c0);
    n = 0;
    while (cyc < c0 + 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("buffered_valid", o_valid, 1);
    rstn = 1'b0;
    #1;
    chk("midframe_reset_outputs",
        {o_enb, o_rd_addr, o_data, o_valid, o_last_map, o_last, busy, done}, 0);
    exp_q.delete();
    addr_q.delete();
    outstanding = 0;
    prev_stall = 0;
    prev_done = 0;
    @(negedge clk);
    rstn = 1'b1;
    run_frame(16'h0300, 3, 2, 0, 1'b0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      mw = $urandom_range(1, 6);
      mn = $urandom_range(1, 3);
      run_frame(AW'($urandom), mw, mn, 1 + (k % 2), 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
